cmos_capture: RTL and testbench
===============================

// Module: cmos_capture
// PURPOSE
//  Converts an 8-bit DVP camera byte stream (OV5640, RGB565, two bytes per pixel)
//  into a 16-bit pixel stream with valid/start-of-packet/end-of-packet flags.
//  Runs in the camera pixel-clock domain, downstream of sensor configuration.
//  Feeds the optional image-processing stage or the SDRAM controller write port.
// PARAMETERS
//  IMG_W        1280  active pixels per line (pixels, not bytes)
//  IMG_H        720   active lines per frame
//  SKIP_FRAMES  2     frames discarded after capture enable (CAPTURE_FRAME_SKIP_EN only)
// PORTS
//  clk         in   1   camera pixel clock (pclk); all logic on rising edge
//  rst         in   1   asynchronous, active-high reset
//  cmos_din    in   8   camera data byte
//  cmos_vsync  in   1   frame sync, active high; a rising edge marks frame start
//  cmos_href   in   1   line valid, active high; one byte per clk while high
//  cap_en      in   1   capture enable (sensor configuration done)
//  pixel       out  16  RGB565 pixel: {first byte, second byte}
//  pixel_vld   out  1   pixel valid, single-cycle pulse per pixel
//  pixel_sop   out  1   first pixel of frame (row 0, col 0), qualified by pixel_vld
//  pixel_eop   out  1   last pixel of frame (row IMG_H-1, col IMG_W-1), qualified by pixel_vld
// BEHAVIOUR
//  - Reset: pixel=0, pixel_vld=0, pixel_sop=0, pixel_eop=0. All counters, phase and state clear; state IDLE.
//  - Input stage: cmos_din, cmos_vsync and cmos_href registered once (din_r, vs_r, href_r).
//    vs_rise = vs_r & ~vs_r_d1.
//  - FSM:
//    IDLE -> WAIT_VS when cap_en=1.
//    WAIT_VS -> CAPTURE on vs_rise with cap_en=1.
//    CAPTURE -> IDLE on vs_rise with cap_en=0.
//    CAPTURE -> CAPTURE on vs_rise with cap_en=1, restarting the frame.
//    In IDLE/WAIT_VS, pixel_vld/sop/eop stay 0.
//    cap_en is evaluated only at frame boundaries; a frame in progress always completes.
//  - On every vs_rise: row=0, col=0, phase=0.
//  - Byte pairing, in CAPTURE with href_r=1:
//    phase 0: hold din_r as the high byte.
//    phase 1: pixel<={hi,din_r}; pixel_vld<=1 if row<IMG_H and col<IMG_W, else pixel dropped.
//    phase toggles on each href_r=1 cycle; forced to 0 while href_r=0.
//    An odd trailing byte in a line is discarded.
//  - Latency: pixel_vld is high for exactly one clk, 2 clks after the second byte is on cmos_din.
//    pixel holds its value until the next valid pixel.
//  - col increments per paired pixel and saturates at IMG_W.
//  - On href_r falling edge with col>0: col=0, row=row+1 (saturates at IMG_H).
//    Lines beyond IMG_H and pixels beyond IMG_W produce no pixel_vld.
//  - pixel_sop = pixel_vld & row==0 & col==0.
//    pixel_eop = pixel_vld & row==IMG_H-1 & col==IMG_W-1.
//    Both are registered together with pixel_vld and are 0 when pixel_vld=0.
//  - Short frame (new vs_rise before eop): no eop emitted. The new frame restarts at sop.
//  - Counter widths: $clog2(IMG_W+1), $clog2(IMG_H+1).
// CONFIGURATION
//  CAPTURE_FRAME_SKIP_EN defined:
//    On entering CAPTURE from WAIT_VS, the first SKIP_FRAMES frames (counted by vs_rise) are consumed
//    with pixel_vld/sop/eop forced to 0. Output starts at frame SKIP_FRAMES+1.
//    The skip counter re-arms whenever the FSM passes through IDLE.
//  CAPTURE_FRAME_SKIP_EN undefined:
//    The first frame after the WAIT_VS->CAPTURE transition is output. SKIP_FRAMES is ignored.
// TESTING  (IMG_W=4, IMG_H=2, macro undefined unless stated)
//  1. Reset held, random inputs -> all outputs 0; release -> outputs stay 0 while cap_en=0.
//  2. cap_en=1, vsync pulse, 2 lines of 8 bytes 0x11..0x18 -> four pixel_vld pulses per line.
//     Line 0 pixels: 0x1112, 0x1314, 0x1516, 0x1718.
//     sop on the first pixel only; eop on the 8th pixel only; total 8 pulses.
//  3. Line of 9 bytes -> 4 pixels; 9th byte dropped; next line starts at col 0 with phase 0.
//  4. Frame with 3 lines / 6 pixels per line -> only the 2x4 window is valid; eop at row1/col3; extras dropped.
//  5. vsync restart mid-frame after 5 pixels -> no eop; next pixel_vld carries sop.
//     cap_en=0 at next vsync -> no further pixel_vld.
//  6. CAPTURE_FRAME_SKIP_EN defined, SKIP_FRAMES=2, 5 frames -> pixel output only in frames 3..5, each with one sop and one eop.

Source files
------------

// File: rtl/cmos_capture.sv
// cmos_capture: pairs DVP RGB565 bytes into 16-bit pixels with valid/sop/eop flags.
// Optional build macro CAPTURE_FRAME_SKIP_EN discards the first SKIP_FRAMES frames after enable.
`default_nettype none

module cmos_capture #(
    parameter int IMG_W       = 1280,
    parameter int IMG_H       = 720,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmos_din,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic        cap_en,
    output logic [15:0] pixel,
    output logic        pixel_vld,
    output logic        pixel_sop,
    output logic        pixel_eop
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [7:0]     din_r, hi_byte;
    logic           vs_r, vs_r_d1, href_r, href_r_d1;
    logic           vs_rise, phase, skipping, out_en, in_window;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_r     <= 8'd0;
            vs_r      <= 1'b0;
            vs_r_d1   <= 1'b0;
            href_r    <= 1'b0;
            href_r_d1 <= 1'b0;
        end else begin
            din_r     <= cmos_din;
            vs_r      <= cmos_vsync;
            vs_r_d1   <= vs_r;
            href_r    <= cmos_href;
            href_r_d1 <= href_r;
        end
    end

    assign vs_rise = vs_r & ~vs_r_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // cap_en only matters at frame boundaries, so a frame in flight always completes.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (cap_en) state_nxt = S_WAIT_VS;
            S_WAIT_VS: if (vs_rise && cap_en) state_nxt = S_CAPTURE;
            S_CAPTURE: if (vs_rise && !cap_en) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

`ifdef CAPTURE_FRAME_SKIP_EN
    localparam int SKW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    logic [SKW-1:0] skip_left;

    // Frame 1 starts with the full count; each later frame start in CAPTURE takes one off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            skip_left <= SKW'(SKIP_FRAMES);
        else if (state == S_IDLE)
            skip_left <= SKW'(SKIP_FRAMES);
        else if (state == S_CAPTURE && vs_rise && cap_en && skip_left != '0)
            skip_left <= skip_left - 1'b1;
    end

    assign skipping = (skip_left != '0);
`else
    assign skipping = (SKIP_FRAMES < 0);
`endif

    assign out_en    = (state == S_CAPTURE) && !skipping;
    assign in_window = (row < ROW_MAX) && (col < COL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row       <= '0;
            col       <= '0;
            phase     <= 1'b0;
            hi_byte   <= 8'd0;
            pixel     <= 16'd0;
            pixel_vld <= 1'b0;
            pixel_sop <= 1'b0;
            pixel_eop <= 1'b0;
        end else begin
            pixel_vld <= 1'b0;
            pixel_sop <= 1'b0;
            pixel_eop <= 1'b0;
            if (vs_rise) begin
                row   <= '0;
                col   <= '0;
                phase <= 1'b0;
            end else if (state == S_CAPTURE) begin
                if (href_r) begin
                    phase <= ~phase;
                    if (!phase) begin
                        hi_byte <= din_r;
                    end else begin
                        if (in_window && out_en) begin
                            pixel     <= {hi_byte, din_r};
                            pixel_vld <= 1'b1;
                            pixel_sop <= (row == '0) && (col == '0);
                            pixel_eop <= (row == ROW_LAST) && (col == COL_LAST);
                        end
                        if (col != COL_MAX) col <= col + 1'b1;
                    end
                end else begin
                    // An odd trailing byte is dropped simply by clearing phase here.
                    phase <= 1'b0;
                    if (href_r_d1 && col != '0) begin
                        col <= '0;
                        if (row != ROW_MAX) row <= row + 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmos_capture.sv
// tb_cmos_capture: directed DVP stimulus against a frame/line/pixel-level model with per-cycle checking.
`default_nettype none

module tb_cmos_capture;

    localparam int W = 4;
    localparam int H = 2;
`ifdef CAPTURE_FRAME_SKIP_EN
    localparam int SKIP = 2;
`else
    localparam int SKIP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cmos_din = 8'd0;
    logic        cmos_vsync = 1'b0;
    logic        cmos_href = 1'b0;
    logic        cap_en = 1'b0;
    logic [15:0] pixel;
    logic        pixel_vld, pixel_sop, pixel_eop;

    cmos_capture #(.IMG_W(W), .IMG_H(H), .SKIP_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .cmos_din(cmos_din), .cmos_vsync(cmos_vsync),
        .cmos_href(cmos_href), .cap_en(cap_en), .pixel(pixel),
        .pixel_vld(pixel_vld), .pixel_sop(pixel_sop), .pixel_eop(pixel_eop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] px;
        logic        sop;
        logic        eop;
        int          cyc;
    } ev_t;

    ev_t q[$];
    ev_t lg[$];
    ev_t ce;
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    // Model state: capturing flag, frames still to skip, current row of the frame.
    bit  m_cap = 0;
    int  m_skip = 0;
    int  m_row = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_pixel actual=none required=%h at cycle %0d", q[0].px, q[0].cyc);
                void'(q.pop_front());
            end
            checks++;
            if (pixel_vld) begin
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pixel actual=%h sop=%b eop=%b required=none (cycle %0d)",
                             pixel, pixel_sop, pixel_eop, cyc);
                end else begin
                    ce = q.pop_front();
                    if (pixel !== ce.px || pixel_sop !== ce.sop || pixel_eop !== ce.eop || ce.cyc != cyc) begin
                        failures++;
                        $display("FAIL pixel_stream actual=%h/%b/%b@%0d required=%h/%b/%b@%0d",
                                 pixel, pixel_sop, pixel_eop, cyc, ce.px, ce.sop, ce.eop, ce.cyc);
                    end
                end
                lg.push_back('{pixel, pixel_sop, pixel_eop, cyc});
            end else if (pixel_sop || pixel_eop) begin
                failures++;
                $display("FAIL flags_without_vld actual=%b%b required=00", pixel_sop, pixel_eop);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic frame_start();
        if (cap_en) begin
            if (!m_cap) m_skip = SKIP;
            else if (m_skip > 0) m_skip--;
            m_cap = 1;
        end else begin
            m_cap = 0;
        end
        m_row = 0;
        cmos_vsync = 1'b1;
        repeat (2) tick();
        cmos_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_line(input int n, input logic [7:0] start);
        logic [7:0] b, hi;
        int k;
        hi = 8'd0;
        for (int i = 0; i < n; i++) begin
            b = start + 8'(i);
            cmos_href = 1'b1;
            cmos_din  = b;
            if (i % 2 == 0) begin
                hi = b;
            end else begin
                k = i / 2;
                if (m_cap && m_skip == 0 && m_row < H && k < W)
                    q.push_back('{{hi, b}, (m_row == 0 && k == 0), (m_row == H-1 && k == W-1), cyc + 2});
            end
            tick();
        end
        cmos_href = 1'b0;
        cmos_din  = 8'($urandom);
        if (n >= 2 && m_row < H) m_row++;
        repeat (3) tick();
    endtask

    function automatic int count_sop(input int from);
        int c = 0;
        for (int i = from; i < lg.size(); i++) if (lg[i].sop) c++;
        return c;
    endfunction

    function automatic int count_eop(input int from);
        int c = 0;
        for (int i = from; i < lg.size(); i++) if (lg[i].eop) c++;
        return c;
    endfunction

    int b;

    initial begin
        // 1. reset with random inputs, then idle with cap_en low
        repeat (8) begin
            cmos_din   = 8'($urandom);
            cmos_vsync = 1'($urandom);
            cmos_href  = 1'($urandom);
            @(negedge clk);
            chk("reset_outputs", {pixel, pixel_vld, pixel_sop, pixel_eop}, 0);
        end
        cmos_vsync = 1'b0;
        cmos_href  = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        frame_start();
        send_line(8, 8'h01);
        chk("idle_no_output", lg.size(), 0);

        // 2. basic 2x4 frame
        cap_en = 1'b1;
        repeat (3) tick();
        b = lg.size();
        frame_start();
        send_line(8, 8'h11);
        send_line(8, 8'h21);
        chk("t2_count", lg.size() - b, 8);
        chk("t2_first_px", lg[b].px, 16'h1112);
        chk("t2_first_sop", lg[b].sop, 1);
        chk("t2_px3", lg[b+3].px, 16'h1718);
        chk("t2_last_px", lg[b+7].px, 16'h2728);
        chk("t2_last_eop", lg[b+7].eop, 1);
        chk("t2_sop_count", count_sop(b), 1);
        chk("t2_eop_count", count_eop(b), 1);

        // 3. odd trailing byte dropped
        b = lg.size();
        frame_start();
        send_line(9, 8'h31);
        send_line(8, 8'h41);
        chk("t3_count", lg.size() - b, 8);
        chk("t3_line1_px0", lg[b+4].px, 16'h4142);
        chk("t3_line1_sop", lg[b+4].sop, 0);

        // 4. oversize frame clipped to window
        b = lg.size();
        frame_start();
        send_line(12, 8'h51);
        send_line(12, 8'h61);
        send_line(12, 8'h71);
        chk("t4_count", lg.size() - b, 8);
        chk("t4_eop_px", lg[b+7].px, 16'h6768);
        chk("t4_eop_count", count_eop(b), 1);

        // 5. short frame restart, then disable
        b = lg.size();
        frame_start();
        send_line(8, 8'h81);
        send_line(2, 8'h91);
        frame_start();
        send_line(8, 8'hA1);
        send_line(8, 8'hB1);
        cap_en = 1'b0;
        frame_start();
        send_line(8, 8'hC1);
        chk("t5_count", lg.size() - b, 13);
        chk("t5_restart_px", lg[b+5].px, 16'hA1A2);
        chk("t5_restart_sop", lg[b+5].sop, 1);
        chk("t5_eop_count", count_eop(b), 1);

        // 6. five frames after re-enable (skip depends on build macro)
        cap_en = 1'b1;
        repeat (3) tick();
        b = lg.size();
        repeat (5) begin
            frame_start();
            send_line(8, 8'hD1);
            send_line(8, 8'hE1);
        end
        chk("t6_count", lg.size() - b, 8 * (5 - SKIP));
        chk("t6_sop_count", count_sop(b), 5 - SKIP);
        chk("t6_eop_count", count_eop(b), 5 - SKIP);

        repeat (5) tick();
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
